// File: rtl/seq_recall_engine.sv
// Memory-game controller: shows a RAM-held digit sequence, checks player
// entries, grows the round on success and keeps per-player/global bests.
module seq_recall_engine #(
    parameter int DIGIT_W   = 4,
    parameter int ADDR_W    = 5,
    parameter int LEN_W     = 5,
    parameter int START_LEN = 3,
    parameter int MAX_LEN   = 16,
    parameter int PLAYERS   = 4,
    parameter int PID_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PID_W-1:0]   player_id,
    input  logic               logout,
    input  logic               tick,
    input  logic               entry_valid,
    input  logic [DIGIT_W-1:0] entry_digit,
    input  logic               timeout,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [DIGIT_W-1:0] ram_rdata,
    output logic [DIGIT_W-1:0] disp_digit,
    output logic               disp_valid,
    output logic               timer_reload,
    output logic               timer_en,
    output logic               busy,
    output logic [LEN_W-1:0]   score,
    output logic               personal_win,
    output logic               global_win,
    output logic               fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_RD,
        S_SHOW_WAIT,
        S_ENT_RD,
        S_ENT_WAIT,
        S_END
    } state_t;

    state_t             r_st;
    state_t             w_nxt;
    logic [PID_W-1:0]   r_pid;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [LEN_W-1:0]   r_score;
    logic [LEN_W-1:0]   r_gbest;
    logic [LEN_W-1:0]   r_best [PLAYERS];
    logic [DIGIT_W-1:0] r_disp;
    logic               r_shown;
    logic               r_dvalid;
    logic               r_reload;
    logic               r_fail;
    logic               r_pwin;
    logic               r_gwin;

    logic [LEN_W-1:0]   w_idx_inc;
    logic               w_last;
    logic               w_match;
    logic               w_at_max;
    logic               w_abort;

    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (w_idx_inc == r_len);
    assign w_match   = (entry_digit == ram_rdata);
    assign w_at_max  = (r_len == LEN_W'(MAX_LEN));
    assign w_abort   = logout && (r_st != S_IDLE);

    assign ram_addr     = ADDR_W'(r_idx);
    assign disp_digit   = r_disp;
    assign disp_valid   = r_dvalid;
    assign timer_reload = r_reload;
    assign timer_en     = (r_st == S_ENT_RD) || (r_st == S_ENT_WAIT);
    assign busy         = (r_st != S_IDLE);
    assign score        = r_score;
    assign personal_win = r_pwin;
    assign global_win   = r_gwin;
    assign fail         = r_fail;

    always_comb begin
        w_nxt = r_st;
        unique case (r_st)
            S_IDLE:      if (start) w_nxt = S_SHOW_RD;
            S_SHOW_RD:   w_nxt = S_SHOW_WAIT;
            S_SHOW_WAIT: begin
                if (r_shown && tick) w_nxt = w_last ? S_ENT_RD : S_SHOW_RD;
            end
            S_ENT_RD:    w_nxt = timeout ? S_END : S_ENT_WAIT;
            S_ENT_WAIT: begin
                if (entry_valid) begin
                    if (!w_match)     w_nxt = S_END;
                    else if (!w_last) w_nxt = S_ENT_RD;
                    else              w_nxt = w_at_max ? S_END : S_SHOW_RD;
                end else if (timeout) begin
                    w_nxt = S_END;
                end
            end
            S_END:       w_nxt = S_IDLE;
            default:     w_nxt = S_IDLE;
        endcase
        if (w_abort) w_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st     <= S_IDLE;
            r_pid    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_score  <= '0;
            r_gbest  <= '0;
            r_disp   <= '0;
            r_shown  <= 1'b0;
            r_dvalid <= 1'b0;
            r_reload <= 1'b0;
            r_fail   <= 1'b0;
            r_pwin   <= 1'b0;
            r_gwin   <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) r_best[p] <= '0;
        end else begin
            r_st     <= w_nxt;
            r_reload <= 1'b0;
            r_fail   <= 1'b0;
            r_pwin   <= 1'b0;
            r_gwin   <= 1'b0;
            if (w_abort) begin
                r_dvalid <= 1'b0;
                r_shown  <= 1'b0;
            end else begin
                case (r_st)
                    S_IDLE: begin
                        if (start) begin
                            r_pid   <= player_id;
                            r_len   <= LEN_W'(START_LEN);
                            r_idx   <= '0;
                            r_score <= '0;
                        end
                    end
                    S_SHOW_WAIT: begin
                        // RAM data is valid on the first cycle here
                        if (!r_shown) begin
                            r_disp   <= ram_rdata;
                            r_dvalid <= 1'b1;
                            r_shown  <= 1'b1;
                        end else if (tick) begin
                            r_dvalid <= 1'b0;
                            r_shown  <= 1'b0;
                            r_idx    <= w_last ? '0 : w_idx_inc;
                            r_reload <= w_last;
                        end
                    end
                    S_ENT_RD: begin
                        if (timeout) r_fail <= 1'b1;
                    end
                    S_ENT_WAIT: begin
                        if (entry_valid) begin
                            if (!w_match) begin
                                r_fail <= 1'b1;
                            end else if (!w_last) begin
                                r_idx    <= w_idx_inc;
                                r_reload <= 1'b1;
                            end else begin
                                r_score <= r_len;
                                if (!w_at_max) begin
                                    r_len <= r_len + 1'b1;
                                    r_idx <= '0;
                                end
                            end
                        end else if (timeout) begin
                            r_fail <= 1'b1;
                        end
                    end
                    S_END: begin
                        if (r_score > r_best[r_pid]) begin
                            r_best[r_pid] <= r_score;
                            r_pwin        <= 1'b1;
                        end
                        if (r_score > r_gbest) begin
                            r_gbest <= r_score;
                            r_gwin  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_recall_engine.sv
// Bench for seq_recall_engine: queue-based game model, per-cycle compare,
// directed scenarios plus randomized play.
module tb_seq_recall_engine;

    localparam int DW   = 4;
    localparam int AW   = 5;
    localparam int LW   = 5;
    localparam int STL  = 3;
    localparam int MAXL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    player_id;
    logic          logout;
    logic          tick;
    logic          entry_valid;
    logic [DW-1:0] entry_digit;
    logic          timeout;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] disp_digit;
    logic          disp_valid;
    logic          timer_reload;
    logic          timer_en;
    logic          busy;
    logic [LW-1:0] score;
    logic          personal_win;
    logic          global_win;
    logic          fail;

    logic [DW-1:0] mem [32];

    seq_recall_engine #(
        .DIGIT_W(DW), .ADDR_W(AW), .LEN_W(LW), .START_LEN(STL),
        .MAX_LEN(MAXL), .PLAYERS(4), .PID_W(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .player_id(player_id),
        .logout(logout), .tick(tick), .entry_valid(entry_valid),
        .entry_digit(entry_digit), .timeout(timeout), .ram_addr(ram_addr),
        .ram_rdata(ram_rdata), .disp_digit(disp_digit),
        .disp_valid(disp_valid), .timer_reload(timer_reload),
        .timer_en(timer_en), .busy(busy), .score(score),
        .personal_win(personal_win), .global_win(global_win), .fail(fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    typedef enum int {P_IDLE, P_SRD, P_SLATCH, P_SHOW, P_ERD, P_EW, P_END} ph_t;

    ph_t m_ph;
    int  m_len, m_score, m_pid, m_gbest, m_disp;
    int  m_best [4];
    int  show_q [$];
    int  ent_q [$];
    bit  m_dvalid, m_reload, m_fail, m_pwin, m_gwin;

    int n_cmp = 0;
    int n_bad = 0;
    int c_reload, c_fail, c_pwin, c_gwin;
    int disp_log [$];
    bit prev_dv;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE;
        m_len = 0; m_score = 0; m_pid = 0; m_gbest = 0; m_disp = 0;
        for (int p = 0; p < 4; p++) m_best[p] = 0;
        show_q.delete(); ent_q.delete();
        m_dvalid = 0; m_reload = 0; m_fail = 0; m_pwin = 0; m_gwin = 0;
    endtask

    function automatic void fill(ref int q [$]);
        q.delete();
        for (int i = 0; i < m_len; i++) q.push_back(int'(mem[i]));
    endfunction

    // Game-level model advanced once per rising edge
    task automatic model_step();
        m_reload = 0; m_fail = 0; m_pwin = 0; m_gwin = 0;
        if (logout && m_ph != P_IDLE) begin
            m_ph = P_IDLE;
            m_dvalid = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (start) begin
                m_pid = int'(player_id); m_len = STL; m_score = 0;
                fill(show_q); m_ph = P_SRD;
            end
            P_SRD: m_ph = P_SLATCH;
            P_SLATCH: begin
                m_disp = show_q[0]; m_dvalid = 1; m_ph = P_SHOW;
            end
            P_SHOW: if (tick) begin
                m_dvalid = 0;
                void'(show_q.pop_front());
                if (show_q.size() == 0) begin
                    fill(ent_q); m_reload = 1; m_ph = P_ERD;
                end else m_ph = P_SRD;
            end
            P_ERD: if (timeout) begin
                m_fail = 1; m_ph = P_END;
            end else m_ph = P_EW;
            P_EW: if (entry_valid) begin
                if (int'(entry_digit) != ent_q[0]) begin
                    m_fail = 1; m_ph = P_END;
                end else begin
                    void'(ent_q.pop_front());
                    if (ent_q.size() > 0) begin
                        m_reload = 1; m_ph = P_ERD;
                    end else begin
                        m_score = m_len;
                        if (m_len == MAXL) m_ph = P_END;
                        else begin
                            m_len++; fill(show_q); m_ph = P_SRD;
                        end
                    end
                end
            end else if (timeout) begin
                m_fail = 1; m_ph = P_END;
            end
            P_END: begin
                if (m_score > m_best[m_pid]) begin
                    m_best[m_pid] = m_score; m_pwin = 1;
                end
                if (m_score > m_gbest) begin
                    m_gbest = m_score; m_gwin = 1;
                end
                m_ph = P_IDLE;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    initial begin
        prev_dv = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("busy", int'(busy), int'(m_ph != P_IDLE));
                chk("timer_en", int'(timer_en), int'(m_ph == P_ERD || m_ph == P_EW));
                chk("disp_valid", int'(disp_valid), int'(m_dvalid));
                chk("timer_reload", int'(timer_reload), int'(m_reload));
                chk("fail", int'(fail), int'(m_fail));
                chk("personal_win", int'(personal_win), int'(m_pwin));
                chk("global_win", int'(global_win), int'(m_gwin));
                chk("score", int'(score), m_score);
                if (m_dvalid) chk("disp_digit", int'(disp_digit), m_disp);
                if (m_ph == P_SRD) chk("ram_addr_show", int'(ram_addr), m_len - show_q.size());
                if (m_ph == P_ERD) chk("ram_addr_ent", int'(ram_addr), m_len - ent_q.size());
                if (timer_reload) c_reload++;
                if (fail) c_fail++;
                if (personal_win) c_pwin++;
                if (global_win) c_gwin++;
                if (disp_valid && !prev_dv) disp_log.push_back(int'(disp_digit));
                prev_dv = disp_valid;
            end else prev_dv = 0;
        end
    end

    task automatic clr();
        c_reload = 0; c_fail = 0; c_pwin = 0; c_gwin = 0;
        disp_log.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        start = 0; entry_valid = 0; timeout = 0; tick = 0; logout = 0;
    endtask

    task automatic auto_cyc();
        if (m_ph == P_SHOW) tick = 1;
        if (m_ph == P_EW) begin
            entry_valid = 1;
            entry_digit = 4'(ent_q[0]);
        end
        cyc();
    endtask

    task automatic run_until(input ph_t ph, input int len_req, input string what);
        int budget = 300;
        while (!(m_ph == ph && (len_req == 0 || m_len == len_req))) begin
            if (budget == 0) begin
                chk(what, 0, 1);
                return;
            end
            budget--;
            auto_cyc();
        end
    endtask

    task automatic start_game(input int p);
        start = 1;
        player_id = 2'(p);
        cyc();
    endtask

    task automatic end_by_timeout();
        timeout = 1;
        cyc();
        cyc();
        cyc();
    endtask

    function automatic int log_at(input int i);
        return (disp_log.size() > i) ? disp_log[i] : -1;
    endfunction

    initial begin
        rst = 0; start = 0; player_id = 0; logout = 0; tick = 0;
        entry_valid = 0; entry_digit = 0; timeout = 0;
        for (int i = 0; i < 32; i++) mem[i] = 4'($urandom);
        mem[0] = 4'd3; mem[1] = 4'd7; mem[2] = 4'd1; mem[3] = 4'd9;
        model_reset();
        clr();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_disp_valid", int'(disp_valid), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_timer_en", int'(timer_en), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_disp_digit", int'(disp_digit), 0);
        #1 rst = 1;

        // full first round for player 1
        start_game(1);
        run_until(P_SRD, 4, "round1_timeout");
        chk("shown_count", disp_log.size(), 3);
        chk("shown_d0", log_at(0), 3);
        chk("shown_d1", log_at(1), 7);
        chk("shown_d2", log_at(2), 1);
        chk("reload_pulses", c_reload, 3);
        chk("round1_score", int'(score), 3);
        chk("round1_nofail", c_fail, 0);

        // timeout in round two
        clr();
        run_until(P_EW, 4, "round2_ew_timeout");
        end_by_timeout();
        chk("to_fail", c_fail, 1);
        chk("to_pwin", c_pwin, 1);
        chk("to_gwin", c_gwin, 1);
        chk("to_score", int'(score), 3);
        chk("model_best1", m_best[1], 3);
        chk("to_idle", int'(busy), 0);

        // wrong second digit for player 3
        clr();
        start_game(3);
        run_until(P_EW, 3, "wrong_ew1");
        auto_cyc();
        run_until(P_EW, 3, "wrong_ew2");
        entry_valid = 1; entry_digit = 4'd5;
        cyc();
        chk("wrong_fail", c_fail, 1);
        chk("wrong_busy_end", int'(busy), 1);
        cyc();
        chk("wrong_idle", int'(busy), 0);
        chk("wrong_score", int'(score), 0);
        chk("wrong_nowin", c_pwin + c_gwin, 0);

        // player 2 ties the global best
        clr();
        start_game(2);
        run_until(P_EW, 4, "p2_ew");
        end_by_timeout();
        chk("tie_pwin", c_pwin, 1);
        chk("tie_gwin", c_gwin, 0);
        chk("model_best2", m_best[2], 3);

        // player 1 repeats its best
        clr();
        start_game(1);
        run_until(P_EW, 4, "p1_ew");
        end_by_timeout();
        chk("repeat_nowin", c_pwin + c_gwin, 0);

        // entry and timeout together, tick in SHOW_RD, run to max length
        clr();
        start_game(0);
        run_until(P_EW, 3, "sim_ew");
        entry_valid = 1; entry_digit = 4'(ent_q[0]); timeout = 1;
        cyc();
        chk("sim_nofail", c_fail, 0);
        chk("sim_still_entry", int'(timer_en), 1);
        run_until(P_SRD, 4, "max_srd");
        tick = 1;
        cyc();
        tick = 1;
        cyc();
        run_until(P_END, 4, "max_end");
        chk("max_score", int'(score), 4);
        chk("max_nofail", c_fail, 0);
        cyc();
        chk("max_pwin", c_pwin, 1);
        chk("max_gwin", c_gwin, 1);
        chk("model_gbest", m_gbest, 4);

        // logout during the show phase
        clr();
        start_game(1);
        run_until(P_SHOW, 3, "lo_show");
        logout = 1;
        cyc();
        chk("lo_idle", int'(busy), 0);
        chk("lo_dv", int'(disp_valid), 0);
        cyc();
        chk("lo_nowin", c_pwin + c_gwin + c_fail, 0);
        chk("lo_best1", m_best[1], 3);

        // asynchronous reset in ENT_WAIT
        clr();
        start_game(2);
        run_until(P_EW, 4, "rst_ew");
        #2 rst = 0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_timer_en", int'(timer_en), 0);
        chk("arst_score", int'(score), 0);
        chk("arst_dv", int'(disp_valid), 0);
        chk("arst_ram_addr", int'(ram_addr), 0);
        chk("arst_digit", int'(disp_digit), 0);
        model_reset();
        @(negedge clk);
        #1 rst = 1;

        // randomized play
        for (int c = 0; c < 5000; c++) begin
            if (m_ph == P_IDLE) begin
                if ($urandom_range(0, 7) == 0)
                    for (int i = 0; i < 4; i++) mem[i] = 4'($urandom);
                start = ($urandom_range(0, 2) == 0);
                player_id = 2'($urandom);
            end else begin
                start = ($urandom_range(0, 19) == 0);
                tick = ($urandom_range(0, 1) == 1);
                timeout = ($urandom_range(0, 29) == 0);
                logout = ($urandom_range(0, 149) == 0);
                if (m_ph == P_ERD || m_ph == P_EW) begin
                    entry_valid = ($urandom_range(0, 2) == 0);
                    entry_digit = (ent_q.size() > 0 && $urandom_range(0, 9) != 0)
                                  ? 4'(ent_q[0]) : 4'($urandom);
                end else begin
                    entry_valid = ($urandom_range(0, 9) == 0);
                    entry_digit = 4'($urandom);
                end
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_recall_engine.md
# seq_recall_engine

Parametrised successor to the memory-game controller. Plays back a stored random-digit sequence from the sequence RAM, collects player entries, and extends the round length on each success. Tracks per-player and global best scores, and raises personal/global win pulses. Sits between the sequencer/RAM, the two-second pacing timer, the entry countdown timer and the 7-segment display decoder; supports `PLAYERS` authenticated users.

## Interface
Parameters:
- `DIGIT_W` = 4 — width of a sequence digit.
- `ADDR_W` = 5 — sequence RAM address width.
- `LEN_W` = 5 — width of round-length and score values.
- `START_LEN` = 3 — length of the first round.
- `MAX_LEN` = 16 — final round length; must satisfy `MAX_LEN` ≤ 2^`ADDR_W` and `MAX_LEN` < 2^`LEN_W`.
- `PLAYERS` = 4 — number of player score slots.
- `PID_W` = 2 — player id width.

Ports:
- `clk` in 1 — single clock; everything is on the rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle pulse (button-shaped); begins a game.
- `player_id` in `PID_W` — sampled on `start`.
- `logout` in 1 — aborts the game immediately.
- `tick` in 1 — display pacing pulse.
- `entry_valid` in 1 — one-cycle pulse; `entry_digit` is valid.
- `entry_digit` in `DIGIT_W` — player's digit.
- `timeout` in 1 — entry timer expired.
- `ram_addr` out `ADDR_W` — RAM read address.
- `ram_rdata` in `DIGIT_W` — RAM data, valid 1 cycle after address.
- `disp_digit` out `DIGIT_W` — digit to display.
- `disp_valid` out 1 — display enable.
- `timer_reload` out 1 — one-cycle pulse that reloads the entry timer.
- `timer_en` out 1 — entry timer run enable.
- `busy` out 1 — high whenever the state is not IDLE.
- `score` out `LEN_W` — last completed round length of the current/last game.
- `personal_win` out 1 — one-cycle pulse.
- `global_win` out 1 — one-cycle pulse.
- `fail` out 1 — one-cycle pulse.

## Operation
States are IDLE, SHOW_RD, SHOW_WAIT, ENT_RD, ENT_WAIT, END.

- **Reset:** state IDLE; all outputs 0; `len`, `idx`, `score` = 0; all `best[p]` = 0; `gbest` = 0.
- **IDLE:** on `start`, latch `player_id` into `pid`, set `len`=`START_LEN`, `idx`=0, `score`=0, go to SHOW_RD. `start` in any other state is ignored.
- **SHOW_RD:** drive `ram_addr`=`idx`, go to SHOW_WAIT.
- **SHOW_WAIT:**
  - First cycle: latch `ram_rdata` into `disp_digit`; `disp_valid`=1.
  - On `tick`: `disp_valid`=0. If `idx`+1 == `len`, set `idx`=0 and go to ENT_RD; else increment `idx` and go to SHOW_RD.
  - `tick` is ignored during the latch cycle and in SHOW_RD.
- **ENT_RD:**
  - On entry from SHOW_WAIT, or after a correct entry: pulse `timer_reload`.
  - Drive `ram_addr`=`idx`; the expected digit is latched next cycle; go to ENT_WAIT.
  - `timer_en`=1 in ENT_RD and ENT_WAIT.
  - `entry_valid` in ENT_RD is ignored.
- **ENT_WAIT:**
  - `entry_valid` with a mismatch → pulse `fail` → END.
  - `entry_valid` with a match, and `idx`+1 < `len` → increment `idx` → ENT_RD.
  - `entry_valid` with a match, and `idx`+1 == `len` → `score`=`len`. If `len`==`MAX_LEN`, go to END (no `fail`). Else increment `len`, set `idx`=0, go to SHOW_RD.
  - `timeout` without `entry_valid` → pulse `fail` → END.
  - `timeout` in ENT_RD also → pulse `fail` → END.
- **END:** takes one cycle.
  - If `score` > `best[pid]`: write `best[pid]` and pulse `personal_win`.
  - If `score` > `gbest`: write `gbest` and pulse `global_win`.
  - Ties do not win. Then go to IDLE.
- **`logout`:** highest priority in any non-IDLE state. Go to IDLE the next cycle; clear `disp_valid` and `timer_en`; no `fail`; no best-score update; `score` is held.

## Timing
- `start` to first `ram_addr` drive: 1 cycle. `disp_valid` rises 2 cycles after `start`.
- All pulse outputs (`timer_reload`, `fail`, `personal_win`, `global_win`) are registered and exactly one cycle wide.
- `entry_valid` and `timeout` in the same ENT_WAIT cycle: the entry wins.
- `score` does not wrap: `len` stops at `MAX_LEN`.
- `best`/`gbest` persist across games; only reset clears them.
- Asserting reset mid-game forces IDLE asynchronously with all outputs 0.

## Test plan
- **Full correct round:** reset, RAM holds 3,7,1,9 at addresses 0-3; `start` with `player_id`=1. Expect `disp_digit` sequence 3,7,1 with one digit per `tick`. Enter 3,7,1 → `score`=3, SHOW restarts with `len`=4, and `timer_reload` pulses once per entry.
- **Wrong entry:** during the entry phase of the first round, enter 3 then 5. Expect `fail` pulse, `score`=0, no win pulses, IDLE 2 cycles later.
- **Timeout after a completed round:** clear the first round, then assert `timeout` during the second round's ENT_WAIT. Expect `fail`, `score`=3, `personal_win` and `global_win` both pulsed (bests were 0), `best[1]`=3.
- **Tie vs. new personal best:** player 2 also reaches 3 → `personal_win` only. Player 1 reaches 3 again → no win pulses.
- **Simultaneous events and ignored inputs:** `entry_valid` (correct digit) and `timeout` in the same cycle → treated as a correct entry, no `fail`. `tick` during SHOW_RD → no index advance.
- **Max length, logout and reset:**
  - `MAX_LEN`=4, `START_LEN`=3, all entries correct → END with `score`=4, no `fail`.
  - `logout` mid-SHOW → IDLE next cycle, `best` unchanged.
  - `rst` low mid-ENT_WAIT → all outputs 0 immediately.
